// File: rtl/leaf_port.sv
// Router-side endpoint of the 16-bit GPU<->router link: validates NI flits into the leaf router
// and returns router flits to the NI under credit control. LEAF_PORT_STATS_EN adds counters.
module leaf_port #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned LOCAL_GROUP = 1,
  parameter int unsigned LOCAL_LEAF  = 3,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned NI_CREDITS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ni_data_in,
  input  logic              ni_valid_in,
  output logic              ni_ready_out,
  output logic [DATA_W-1:0] ni_data_out,
  output logic              ni_valid_out,
  input  logic              ni_credit_in,
  output logic [DATA_W-1:0] net_data_out,
  output logic              net_valid_out,
  input  logic              net_ready_in,
  output logic              net_dst_local,
  input  logic [DATA_W-1:0] net_data_in,
  input  logic              net_valid_in,
  output logic              net_ready_out,
  output logic              err_hdr,
  output logic              ovf_sticky
`ifdef LEAF_PORT_STATS_EN
  ,
  output logic [15:0]       stat_up,
  output logic [15:0]       stat_down,
  output logic [15:0]       stat_drop
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned KW = $clog2(NI_CREDITS + 1);
  localparam logic [CW-1:0] Depth    = CW'(FIFO_DEPTH);
  localparam logic [KW-1:0] MaxCred  = KW'(NI_CREDITS);
  localparam logic [3:0]    LocGroup = 4'(LOCAL_GROUP);
  localparam logic [1:0]    LocLeaf  = 2'(LOCAL_LEAF);

  typedef enum logic {StIdle, StHold} up_state_e;

  logic [DATA_W-1:0] ing_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] eg_mem  [FIFO_DEPTH];

  up_state_e         up_state_q, up_state_d;
  logic [AW-1:0]     ing_wr_q, ing_wr_d, ing_rd_q, ing_rd_d;
  logic [AW-1:0]     eg_wr_q, eg_wr_d, eg_rd_q, eg_rd_d;
  logic [CW-1:0]     ing_count_q, ing_count_d, eg_count_q, eg_count_d;
  logic [KW-1:0]     credits_q, credits_d;
  logic [DATA_W-1:0] net_data_q, net_data_d, ni_data_q, ni_data_d;
  logic              net_dst_q, net_dst_d, ni_valid_q, ni_valid_d;
  logic              err_q, err_d, ovf_q, ovf_d;

  logic [5:0] ing_hdr;
  logic       ing_bad, ing_full, ing_pop, ing_push, ing_drop;
  logic       eg_acc, eg_bad, eg_push, eg_pop;

  assign ing_hdr  = ni_data_in[DATA_W-1 -: 6];
  assign ing_bad  = ni_valid_in && ((ing_hdr == 6'b000000) || (ing_hdr[5:2] > 4'd8));
  assign ing_full = (ing_count_q == Depth);
  // Head moves into the output register whenever that register is free or being accepted.
  assign ing_pop  = (ing_count_q != '0) && ((up_state_q == StIdle) || net_ready_in);
  assign ing_push = ni_valid_in && !ing_bad && (!ing_full || ing_pop);
  assign ing_drop = ni_valid_in && !ing_bad && ing_full && !ing_pop;

  assign eg_acc  = net_valid_in && net_ready_out;
  assign eg_bad  = eg_acc && (net_data_in[DATA_W-1 -: 6] != {LocGroup, LocLeaf});
  assign eg_push = eg_acc && !eg_bad;
  assign eg_pop  = (eg_count_q != '0) && (credits_q != '0);

  assign ni_ready_out  = (ing_count_q < Depth - CW'(1));
  assign net_ready_out = (eg_count_q < Depth);
  assign net_data_out  = net_data_q;
  assign net_valid_out = (up_state_q == StHold);
  assign net_dst_local = net_dst_q;
  assign ni_data_out   = ni_data_q;
  assign ni_valid_out  = ni_valid_q;
  assign err_hdr       = err_q;
  assign ovf_sticky    = ovf_q;

  always_comb begin
    up_state_d = up_state_q;
    net_data_d = net_data_q;
    net_dst_d  = net_dst_q;
    unique case (up_state_q)
      StIdle: begin
        if (ing_pop) begin
          net_data_d = ing_mem[ing_rd_q];
          net_dst_d  = (ing_mem[ing_rd_q][DATA_W-1 -: 4] == LocGroup);
          up_state_d = StHold;
        end
      end
      StHold: begin
        if (ing_pop) begin
          net_data_d = ing_mem[ing_rd_q];
          net_dst_d  = (ing_mem[ing_rd_q][DATA_W-1 -: 4] == LocGroup);
        end else if (net_ready_in) begin
          net_dst_d  = 1'b0;
          up_state_d = StIdle;
        end
      end
      default: up_state_d = StIdle;
    endcase
  end

  always_comb begin
    ing_wr_d    = ing_wr_q + AW'(ing_push);
    ing_rd_d    = ing_rd_q + AW'(ing_pop);
    ing_count_d = ing_count_q + CW'(ing_push) - CW'(ing_pop);
    eg_wr_d     = eg_wr_q + AW'(eg_push);
    eg_rd_d     = eg_rd_q + AW'(eg_pop);
    eg_count_d  = eg_count_q + CW'(eg_push) - CW'(eg_pop);
    ni_valid_d  = eg_pop;
    ni_data_d   = eg_pop ? eg_mem[eg_rd_q] : ni_data_q;
    credits_d   = credits_q;
    if (eg_pop && !ni_credit_in) begin
      credits_d = credits_q - KW'(1);
    end else if (!eg_pop && ni_credit_in && (credits_q < MaxCred)) begin
      credits_d = credits_q + KW'(1);
    end
    err_d = ing_bad || eg_bad;
    ovf_d = ovf_q || ing_drop;
  end

  always_ff @(posedge clk) begin
    if (ing_push) ing_mem[ing_wr_q] <= ni_data_in;
    if (eg_push)  eg_mem[eg_wr_q]   <= net_data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      up_state_q  <= StIdle;
      ing_wr_q    <= '0;
      ing_rd_q    <= '0;
      ing_count_q <= '0;
      eg_wr_q     <= '0;
      eg_rd_q     <= '0;
      eg_count_q  <= '0;
      credits_q   <= MaxCred;
      net_data_q  <= '0;
      net_dst_q   <= 1'b0;
      ni_data_q   <= '0;
      ni_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      up_state_q  <= up_state_d;
      ing_wr_q    <= ing_wr_d;
      ing_rd_q    <= ing_rd_d;
      ing_count_q <= ing_count_d;
      eg_wr_q     <= eg_wr_d;
      eg_rd_q     <= eg_rd_d;
      eg_count_q  <= eg_count_d;
      credits_q   <= credits_d;
      net_data_q  <= net_data_d;
      net_dst_q   <= net_dst_d;
      ni_data_q   <= ni_data_d;
      ni_valid_q  <= ni_valid_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef LEAF_PORT_STATS_EN
  logic [15:0] stat_up_q, stat_up_d, stat_down_q, stat_down_d, stat_drop_q, stat_drop_d;
  logic [16:0] up_sum, down_sum, drop_sum;

  always_comb begin
    up_sum      = {1'b0, stat_up_q} + 17'(net_valid_out && net_ready_in);
    down_sum    = {1'b0, stat_down_q} + 17'(eg_pop);
    // Ingress and egress discards can land in the same cycle.
    drop_sum    = {1'b0, stat_drop_q} + 17'(ing_drop || ing_bad) + 17'(eg_bad);
    stat_up_d   = up_sum[16] ? 16'hFFFF : up_sum[15:0];
    stat_down_d = down_sum[16] ? 16'hFFFF : down_sum[15:0];
    stat_drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_up_q   <= '0;
      stat_down_q <= '0;
      stat_drop_q <= '0;
    end else begin
      stat_up_q   <= stat_up_d;
      stat_down_q <= stat_down_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign stat_up   = stat_up_q;
  assign stat_down = stat_down_q;
  assign stat_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_leaf_port.sv
// Directed self-checking bench for leaf_port (default build): ingress, up stage, headers,
// credits, simultaneous push/pop and mid-stream reset.
module tb_leaf_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ni_data_in, ni_data_out, net_data_out, net_data_in;
  logic        ni_valid_in, ni_ready_out, ni_valid_out, ni_credit_in;
  logic        net_valid_out, net_ready_in, net_dst_local, net_valid_in, net_ready_out;
  logic        err_hdr, ovf_sticky;

  int vectors = 0;
  int miscompares = 0;
  int p;

  leaf_port dut (
    .clk          (clk),
    .reset        (reset),
    .ni_data_in   (ni_data_in),
    .ni_valid_in  (ni_valid_in),
    .ni_ready_out (ni_ready_out),
    .ni_data_out  (ni_data_out),
    .ni_valid_out (ni_valid_out),
    .ni_credit_in (ni_credit_in),
    .net_data_out (net_data_out),
    .net_valid_out(net_valid_out),
    .net_ready_in (net_ready_in),
    .net_dst_local(net_dst_local),
    .net_data_in  (net_data_in),
    .net_valid_in (net_valid_in),
    .net_ready_out(net_ready_out),
    .err_hdr      (err_hdr),
    .ovf_sticky   (ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive n egress flits back-to-back, then idle; count ni_valid_out pulses over the window.
  task automatic egress(input int n, input logic [15:0] d, input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      net_valid_in = (i < n);
      net_data_in  = d;
      tick();
      if (ni_valid_out) pulses++;
    end
    net_valid_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ni_data_in = '0; ni_valid_in = 1'b0; ni_credit_in = 1'b0;
    net_data_in = '0; net_valid_in = 1'b0; net_ready_in = 1'b0;
    tick(); tick();
    reset = 1'b0;

    chk("rst_ni_ready", ni_ready_out, 1);
    chk("rst_net_ready", net_ready_out, 1);
    chk("rst_net_valid", net_valid_out, 0);
    chk("rst_ni_valid", ni_valid_out, 0);
    chk("rst_err", err_hdr, 0);
    chk("rst_ovf", ovf_sticky, 0);
    chk("rst_dst", net_dst_local, 0);

    // Single flit to the router
    ni_data_in = 16'h1C2A; ni_valid_in = 1'b1; tick(); ni_valid_in = 1'b0;
    chk("t1_latency", net_valid_out, 0);
    tick();
    chk("t1_valid", net_valid_out, 1);
    chk("t1_data", net_data_out, 16'h1C2A);
    chk("t1_dst", net_dst_local, 1);
    tick(); tick();
    chk("t1_hold_valid", net_valid_out, 1);
    chk("t1_hold_data", net_data_out, 16'h1C2A);
    net_ready_in = 1'b1; tick(); net_ready_in = 1'b0;
    chk("t1_release", net_valid_out, 0);

    // Bad headers: unknown-ID code and group 9
    ni_data_in = 16'h03FF; ni_valid_in = 1'b1; tick(); ni_valid_in = 1'b0;
    chk("t3_err", err_hdr, 1);
    tick();
    chk("t3_err_pulse", err_hdr, 0);
    chk("t3_no_valid", net_valid_out, 0);
    ni_data_in = 16'h9400; ni_valid_in = 1'b1; tick(); ni_valid_in = 1'b0;
    chk("t3_grp9_err", err_hdr, 1);
    tick();
    chk("t3_grp9_no_valid", net_valid_out, 0);

    // Backpressure: park a remote-group flit in the output register, then fill the FIFO
    ni_data_in = 16'h2055; ni_valid_in = 1'b1; tick(); ni_valid_in = 1'b0; tick();
    chk("t2_pre_data", net_data_out, 16'h2055);
    chk("t2_pre_dst", net_dst_local, 0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_ready_%0d", k), ni_ready_out, (k < 7));
      ni_data_in = 16'h1C00 + 16'(k); ni_valid_in = 1'b1; tick();
    end
    ni_valid_in = 1'b0;
    chk("t2_full_ready", ni_ready_out, 0);
    chk("t2_no_ovf", ovf_sticky, 0);

    // Write and read in the same cycle while full
    ni_data_in = 16'h1CEE; ni_valid_in = 1'b1; net_ready_in = 1'b1; tick();
    ni_valid_in = 1'b0; net_ready_in = 1'b0;
    chk("t5_no_drop", ovf_sticky, 0);
    chk("t5_still_full", ni_ready_out, 0);
    chk("t5_next", net_data_out, 16'h1C00);

    ni_data_in = 16'h1C99; ni_valid_in = 1'b1; tick(); ni_valid_in = 1'b0;
    chk("t2_ovf", ovf_sticky, 1);

    net_ready_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("t2_drain_%0d", k), net_data_out, (k < 8) ? 16'h1C00 + 16'(k) : 16'h1CEE);
    end
    tick();
    chk("t2_drain_empty", net_valid_out, 0);
    net_ready_in = 1'b0;

    // Credits: 10 flits, 8 credits
    egress(10, 16'h1FAB, 20, p);
    chk("t4_pulses", p, 8);
    chk("t4_data", ni_data_out, 16'h1FAB);
    chk("t4_ready", net_ready_out, 1);
    net_data_in = 16'h1800; net_valid_in = 1'b1; tick(); net_valid_in = 1'b0;
    chk("t4_bad_err", err_hdr, 1);
    ni_credit_in = 1'b1; tick(); ni_credit_in = 1'b0;
    chk("t4_cred_wait", ni_valid_out, 0);
    tick();
    chk("t4_ninth", ni_valid_out, 1);
    tick();
    chk("t4_stall", ni_valid_out, 0);

    // Send and credit in the same cycle
    ni_credit_in = 1'b1; tick();
    net_data_in = 16'h1FAB; net_valid_in = 1'b1; tick();
    ni_credit_in = 1'b0; net_valid_in = 1'b0;
    chk("t5_send", ni_valid_out, 1);
    tick();
    chk("t5_cred_kept", ni_valid_out, 1);
    tick();
    chk("t5_cred_zero", ni_valid_out, 0);

    // Credit saturation: 9 pulses leave only 8 credits
    ni_credit_in = 1'b1; repeat (9) tick(); ni_credit_in = 1'b0;
    egress(10, 16'h1FAB, 25, p);
    chk("t4_sat", p, 8);

    // Reset mid-stream with 5 ingress flits buffered
    ni_valid_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ni_data_in = 16'h1C50 + 16'(k); tick();
    end
    ni_valid_in = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_net_valid", net_valid_out, 0);
    chk("t6_ni_valid", ni_valid_out, 0);
    chk("t6_ni_ready", ni_ready_out, 1);
    chk("t6_net_ready", net_ready_out, 1);
    chk("t6_ovf", ovf_sticky, 0);
    net_ready_in = 1'b1; repeat (3) tick();
    chk("t6_flushed", net_valid_out, 0);
    net_ready_in = 1'b0;
    egress(10, 16'h1FAB, 25, p);
    chk("t6_credits", p, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
